microc_uc: RTL
==============

MICROC_UC -- requirements
Module: microc_uc

Interface
- REQ-001 Parameter OPW, default 6, opcode width; SHALL be at least max(ALUW+1, 5).
- REQ-002 Parameter ALUW, default 3, ALU operation-select width.
- REQ-003 Parameter STACK_DEPTH, default 4, maximum return-stack occupancy tracked by the unit.
- REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge.
- REQ-005 reset  in  1  asynchronous, active-low reset.
- REQ-006 opcode  in  OPW  instruction opcode from instruction memory.
- REQ-007 zero  in  1  registered ALU zero flag.
- REQ-008 imem_ready  in  1  opcode valid this cycle.
- REQ-009 fetch  out  1  instruction request.
- REQ-010 pc_we  out  1  PC update enable.
- REQ-011 s_inc  out  1  1 = PC+1, 0 = load jump target.
- REQ-012 s_inm  out  1  register write-data select: 1 = immediate, 0 = ALU.
- REQ-013 we  out  1  register-file write enable.
- REQ-014 wez  out  1  zero-flag write enable.
- REQ-015 AluOP  out  ALUW  ALU operation.
- REQ-016 s_push, s_pop  out  1 each  return-stack push or pop strobe.
- REQ-017 sp  out  clog2(STACK_DEPTH+1)  current stack occupancy.
- REQ-018 halted, stk_err  out  1 each  halt state; sticky stack error.

Function
- REQ-019 The unit SHALL implement FSM states FETCH, EXEC and HALT, with outputs decoded combinationally from the state and the instruction register (ir).
- REQ-020 In FETCH: fetch=1, all other strobes 0, AluOP=0; if imem_ready=1, ir<=opcode and next state is EXEC; otherwise the FSM stays in FETCH.
- REQ-021 Latency: an opcode accepted at edge N SHALL drive its strobes for exactly the one cycle after N, then the FSM SHALL return to FETCH, or go to HALT for the halt instruction.
- REQ-022 In EXEC: pc_we=1 and fetch=0 for every instruction except HALT.
- REQ-023 ALU class, ir[OPW-1]=0: AluOP=ir[OPW-2 -: ALUW], we=1, wez=1, s_inm=0, s_inc=1.
- REQ-024 LI class, ir[OPW-1:OPW-2]=10: s_inm=1, we=1, wez=0, s_inc=1, AluOP=0.
- REQ-025 Control class, ir[OPW-1:OPW-2]=11: sub=ir[OPW-3 -: 3]; we=0, wez=0.
  - sub=000 J: s_inc=0.
  - sub=001 JZ: s_inc=~zero.
  - sub=010 JNZ: s_inc=zero.
  - sub=011 CALL: s_push=1, s_inc=0, sp+1.
  - sub=100 RET: s_pop=1, s_inc=0, sp-1.
  - sub=111 HALT: pc_we=0; next state HALT.
  - sub=101, 110: NOP with s_inc=1.
- REQ-026 zero SHALL be sampled combinationally during the EXEC cycle, not at fetch.
- REQ-027 CALL with sp==STACK_DEPTH SHALL set stk_err=1, suppress s_push, leave sp unchanged, and force s_inc=1.
- REQ-028 RET with sp==0 SHALL set stk_err=1, suppress s_pop, leave sp unchanged, and force s_inc=1.
- REQ-029 stk_err SHALL remain set until reset.
- REQ-030 HALT SHALL be terminal: halted=1, all strobes 0, fetch=0, imem_ready ignored; only reset exits it.
- REQ-031 s_push and s_pop SHALL never both be asserted; sp SHALL never exceed STACK_DEPTH or wrap below 0.

Reset
- REQ-032 reset=0 SHALL immediately, without waiting for clk, force state=FETCH, ir=0, sp=0, stk_err=0, halted=0.
- REQ-033 Consequently, during and after reset: fetch=1, pc_we=0, we=0, wez=0, s_inm=0, s_inc=0, s_push=0, s_pop=0, AluOP=0.
- REQ-034 Reset asserted mid-EXEC SHALL abort that instruction's strobes in the same cycle; sp and stk_err SHALL clear.
- REQ-035 Deassertion SHALL take effect at the first following rising clk edge.

Verification (OPW=6, ALUW=3, STACK_DEPTH=2)
- REQ-036 Load immediate: opcode=100000, imem_ready=1 -> next cycle s_inm=1, we=1, wez=0, s_inc=1, pc_we=1, AluOP=000; then fetch=1.
- REQ-037 ALU op: opcode=001000 -> AluOP=010, we=1, wez=1, s_inm=0, s_inc=1.
- REQ-038 Conditional jump: JZ opcode=110010 with zero=1 -> s_inc=0, pc_we=1; repeated with zero=0 -> s_inc=1; JNZ 110100 with zero=0 -> s_inc=0.
- REQ-039 Stack limits:
  - CALL 110110 three times -> s_push on the first two, sp=1 then 2; third: s_push=0, s_inc=1, stk_err=1, sp=2.
  - Then RET 111000 three times -> sp=1, 0, then stk_err stays 1 with s_pop=0 on the third.
- REQ-040 Fetch stall: imem_ready=0 for 3 cycles -> fetch=1, pc_we=0 throughout; opcode latched on the cycle imem_ready=1.
- REQ-041 Halt and async reset: HALT 111110 -> halted=1, fetch=0, imem_ready ignored for 5 cycles; reset=0 pulsed mid-cycle -> halted=0, fetch=1 before the next edge.

Source files
------------

// File: rtl/microc_uc.sv
// Microcoded control unit: fetch/exec/halt sequencer that decodes opcodes into
// datapath strobes and tracks a bounded return stack with a sticky overflow/underflow error.
module microc_uc #(
   parameter int unsigned OPW         = 6,
   parameter int unsigned ALUW        = 3,
   parameter int unsigned STACK_DEPTH = 4,
   localparam int unsigned SPW        = $clog2(STACK_DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [OPW-1:0]  opcode,
   input  logic            zero,
   input  logic            imem_ready,
   output logic            fetch,
   output logic            pc_we,
   output logic            s_inc,
   output logic            s_inm,
   output logic            we,
   output logic            wez,
   output logic [ALUW-1:0] AluOP,
   output logic            s_push,
   output logic            s_pop,
   output logic [SPW-1:0]  sp,
   output logic            halted,
   output logic            stk_err
);

   typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2} state_e;

   localparam logic [2:0] SUB_J    = 3'b000;
   localparam logic [2:0] SUB_JZ   = 3'b001;
   localparam logic [2:0] SUB_JNZ  = 3'b010;
   localparam logic [2:0] SUB_CALL = 3'b011;
   localparam logic [2:0] SUB_RET  = 3'b100;
   localparam logic [2:0] SUB_HALT = 3'b111;

   state_e           state_q, state_d;
   logic [OPW-1:0]   ir_q, ir_d;
   logic [SPW-1:0]   sp_q, sp_d;
   logic             stk_err_q, stk_err_d;
   logic [2:0]       sub;
   logic             unused_ir;

   assign sub       = ir_q[OPW-3 -: 3];
   assign unused_ir = ^ir_q;
   assign sp        = sp_q;
   assign stk_err   = stk_err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= FETCH;
         ir_q      <= '0;
         sp_q      <= '0;
         stk_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         sp_q      <= sp_d;
         stk_err_q <= stk_err_d;
      end
   end

   // Next state and strobe decode; strobes follow state so reset kills them at once.
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      sp_d      = sp_q;
      stk_err_d = stk_err_q;
      fetch     = 1'b0;
      pc_we     = 1'b0;
      s_inc     = 1'b0;
      s_inm     = 1'b0;
      we        = 1'b0;
      wez       = 1'b0;
      AluOP     = '0;
      s_push    = 1'b0;
      s_pop     = 1'b0;
      halted    = 1'b0;
      unique case (state_q)
         FETCH: begin
            fetch = 1'b1;
            if (imem_ready) begin
               ir_d    = opcode;
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = FETCH;
            pc_we   = 1'b1;
            if (!ir_q[OPW-1]) begin
               AluOP = ir_q[OPW-2 -: ALUW];
               we    = 1'b1;
               wez   = 1'b1;
               s_inc = 1'b1;
            end else if (!ir_q[OPW-2]) begin
               s_inm = 1'b1;
               we    = 1'b1;
               s_inc = 1'b1;
            end else begin
               unique case (sub)
                  SUB_J:   s_inc = 1'b0;
                  SUB_JZ:  s_inc = ~zero;
                  SUB_JNZ: s_inc = zero;
                  // Stack faults fall through to the next instruction.
                  SUB_CALL: begin
                     if (sp_q == SPW'(STACK_DEPTH)) begin
                        stk_err_d = 1'b1;
                        s_inc     = 1'b1;
                     end else begin
                        s_push = 1'b1;
                        sp_d   = sp_q + SPW'(1);
                     end
                  end
                  SUB_RET: begin
                     if (sp_q == '0) begin
                        stk_err_d = 1'b1;
                        s_inc     = 1'b1;
                     end else begin
                        s_pop = 1'b1;
                        sp_d  = sp_q - SPW'(1);
                     end
                  end
                  SUB_HALT: begin
                     pc_we   = 1'b0;
                     state_d = HALT;
                  end
                  default: s_inc = 1'b1;
               endcase
            end
         end
         HALT:    halted  = 1'b1;
         default: state_d = FETCH;
      endcase
   end

endmodule
